// File: rtl/pb_pkg.sv
// Shared types and constants for the processing block and its main-memory port.
package pb_pkg;

  localparam int unsigned LANES  = 16;
  localparam int unsigned LANE_W = 32;
  localparam int unsigned WORD_W = LANES * LANE_W;
  localparam int unsigned ADDR_W = 16;

  typedef logic [WORD_W-1:0] vec_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    vec_t              data;
  } wbuf_entry_t;

  // Replicate one lane value across every lane of a vector word.
  function automatic vec_t splat_lane(input logic [LANE_W-1:0] v);
    vec_t r;
    for (int i = 0; i < int'(LANES); i++) begin
      r[i*LANE_W +: LANE_W] = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/pb_wbuf.sv
// Posted-write circular FIFO with a combinational youngest-match lookup port.
module pb_wbuf
  import pb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  vec_t              push_data_i,
  input  logic              pop_i,
  output wbuf_entry_t       head_c,
  output logic              empty_c,
  output logic              full_c,
  input  logic [ADDR_W-1:0] lk_addr_i,
  output logic              lk_hit_c,
  output vec_t              lk_data_c
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  wbuf_entry_t ent_q [DEPTH];
  wbuf_entry_t ent_d [DEPTH];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign head_c  = ent_q[head_q];

  // Pointer, count and entry update; push and pop never target the same slot.
  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    if (push_i) begin
      ent_d[tail_q] = '{valid: 1'b1, addr: push_addr_i, data: push_data_i};
      tail_d        = tail_q + IDX_W'(1);
    end
    if (pop_i) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i].valid <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  // Walk oldest to youngest so the last match found is the youngest store.
  always_comb begin
    logic [IDX_W-1:0] idx;
    lk_hit_c  = 1'b0;
    lk_data_c = '0;
    idx       = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = head_q + IDX_W'(k);
      if ((CNT_W'(k) < count_q) && ent_q[idx].valid && (ent_q[idx].addr == lk_addr_i)) begin
        lk_hit_c  = 1'b1;
        lk_data_c = ent_q[idx].data;
      end
    end
  end

endmodule

// File: rtl/pb_mem_port.sv
// Main-memory port: backing array, posted-write buffer, host preload and 1-cycle load path.
module pb_mem_port #(
  parameter int unsigned LANES      = 16,
  parameter int unsigned LANE_W     = 32,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load_ctrl,
  input  logic [ADDR_W-1:0]         load_addr,
  output logic [LANES*LANE_W-1:0]   load_data,
  output logic                      load_valid,
  input  logic                      write_ctrl,
  input  logic [ADDR_W-1:0]         write_addr,
  input  logic [LANES*LANE_W-1:0]   write_data,
  output logic                      stall,
  input  logic                      host_we,
  input  logic [ADDR_W-1:0]         host_addr,
  input  logic [LANES*LANE_W-1:0]   host_wdata
);

  import pb_pkg::*;

  localparam int unsigned PORT_W = LANES * LANE_W;
  localparam int unsigned MEM_AW = $clog2(DEPTH);

  logic [PORT_W-1:0] mem_q [DEPTH];

  logic [MEM_AW-1:0] ld_idx_c, wr_idx_c, host_idx_c, drain_idx_c;
  logic              push_c, pop_c, empty_c, full_c, lk_hit_c;
  wbuf_entry_t       head_c;
  vec_t              lk_data_c;
  logic              unused_addr_bits_c;

  logic              load_valid_q, load_valid_d;
  logic [PORT_W-1:0] load_data_q, load_data_d;

  // Addresses wrap modulo DEPTH on every port, forwarding compares included.
  assign ld_idx_c    = load_addr[MEM_AW-1:0];
  assign wr_idx_c    = write_addr[MEM_AW-1:0];
  assign host_idx_c  = host_addr[MEM_AW-1:0];
  assign drain_idx_c = head_c.addr[MEM_AW-1:0];

  assign unused_addr_bits_c = ^{load_addr[ADDR_W-1:MEM_AW], write_addr[ADDR_W-1:MEM_AW],
                                host_addr[ADDR_W-1:MEM_AW], head_c.addr[ADDR_W-1:MEM_AW],
                                head_c.valid};

  assign stall  = full_c;
  assign push_c = write_ctrl && !full_c && !reset;
  assign pop_c  = !empty_c && !host_we && !reset;

  pb_wbuf #(
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (push_c),
    .push_addr_i (ADDR_W'(wr_idx_c)),
    .push_data_i (write_data),
    .pop_i       (pop_c),
    .head_c      (head_c),
    .empty_c     (empty_c),
    .full_c      (full_c),
    .lk_addr_i   (ADDR_W'(ld_idx_c)),
    .lk_hit_c    (lk_hit_c),
    .lk_data_c   (lk_data_c)
  );

  // Host writes take the array port; otherwise the buffer head drains.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (host_we) begin
        mem_q[host_idx_c] <= host_wdata;
      end else if (!empty_c) begin
        mem_q[drain_idx_c] <= head_c.data;
      end
    end
  end

  // Load source priority: same-cycle store, buffered store, same-cycle host write, array.
  always_comb begin
    load_valid_d = load_ctrl;
    load_data_d  = load_data_q;
    if (load_ctrl) begin
      if (push_c && (wr_idx_c == ld_idx_c)) begin
        load_data_d = write_data;
      end else if (lk_hit_c) begin
        load_data_d = lk_data_c;
      end else if (host_we && (host_idx_c == ld_idx_c)) begin
        load_data_d = host_wdata;
      end else begin
        load_data_d = mem_q[ld_idx_c];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
    end else begin
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
    end
  end

  assign load_valid = load_valid_q;
  assign load_data  = load_data_q;

endmodule

// File: tb/tb_pb_mem_port.sv
// Scoreboard bench for pb_mem_port: reference buffer/memory model predicts every load result.
module tb_pb_mem_port;
  import pb_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_ctrl, write_ctrl, host_we;
  logic [15:0] load_addr, write_addr, host_addr;
  vec_t        load_data, write_data, host_wdata;
  logic        load_valid, stall;

  always #5 clock = ~clock;

  pb_mem_port dut (
    .clock      (clock),
    .reset      (reset),
    .load_ctrl  (load_ctrl),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_valid (load_valid),
    .write_ctrl (write_ctrl),
    .write_addr (write_addr),
    .write_data (write_data),
    .stall      (stall),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata)
  );

  typedef struct {
    logic [7:0] a;
    vec_t       d;
  } ent_t;

  ent_t mq[$];
  vec_t mem_m [256];
  vec_t sb[$];
  logic exp_valid;
  vec_t last_data;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic vec_t splat(input logic [31:0] v);
    return {16{v}};
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Predict, advance one clock, then compare outputs 1 ns after the edge.
  task automatic step();
    logic       acc, found;
    logic [7:0] la, wa, ha;
    vec_t       e;
    la = load_addr[7:0];
    wa = write_addr[7:0];
    ha = host_addr[7:0];
    if (reset) begin
      mq.delete();
      sb.delete();
      exp_valid = 1'b0;
      last_data = '0;
    end else begin
      acc       = write_ctrl && (mq.size() != 4);
      exp_valid = load_ctrl;
      if (load_ctrl) begin
        found = 1'b0;
        e     = '0;
        if (acc && wa == la) begin
          e     = write_data;
          found = 1'b1;
        end else begin
          foreach (mq[i]) if (mq[i].a == la) begin
            e     = mq[i].d;
            found = 1'b1;
          end
        end
        if (!found) e = (host_we && ha == la) ? host_wdata : mem_m[la];
        sb.push_back(e);
      end
      if (host_we) mem_m[ha] = host_wdata;
      else if (mq.size() > 0) begin
        mem_m[mq[0].a] = mq[0].d;
        void'(mq.pop_front());
      end
      if (acc) mq.push_back('{wa, write_data});
    end
    @(posedge clock);
    #1;
    check("load_valid", 512'(load_valid), 512'(exp_valid));
    check("stall", 512'(stall), 512'(mq.size() == 4));
    if (load_valid && sb.size() > 0) last_data = sb.pop_front();
    check("load_data", load_data, last_data);
    load_ctrl  = 1'b0;
    write_ctrl = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset      = 1'b1;
    load_ctrl  = 1'b0;
    write_ctrl = 1'b0;
    host_we    = 1'b0;
    load_addr  = '0;
    write_addr = '0;
    host_addr  = '0;
    write_data = '0;
    host_wdata = '0;
    exp_valid  = 1'b0;
    last_data  = '0;
    foreach (mem_m[i]) mem_m[i] = '0;
    idle(2);
    reset = 1'b0;

    // Host preload of the whole array, then the 3/5/7 pattern.
    for (int a = 0; a < 256; a++) begin
      host_we = 1'b1; host_addr = 16'(a); host_wdata = splat(32'h1000 + 32'(a));
      step();
    end
    for (int a = 0; a < 3; a++) begin
      host_addr = 16'(a); host_wdata = splat(32'(3 + 2 * a));
      step();
    end
    host_we = 1'b0;
    for (int a = 0; a < 3; a++) begin
      load_ctrl = 1'b1; load_addr = 16'(a);
      step();
    end
    idle(2);

    // Same-cycle store and load.
    write_ctrl = 1'b1; write_addr = 16'd3; write_data = splat(32'd22);
    load_ctrl  = 1'b1; load_addr  = 16'd3;
    step();
    idle(3);

    // Full buffer with the drain blocked, dropped fifth store, release.
    host_we = 1'b1; host_addr = 16'd200; host_wdata = splat(32'h0000_0C8C);
    for (int a = 10; a < 14; a++) begin
      write_ctrl = 1'b1; write_addr = 16'(a); write_data = splat(32'h100 + 32'(a));
      step();
    end
    write_ctrl = 1'b1; write_addr = 16'd14; write_data = splat(32'hDEAD);
    step();
    host_we = 1'b0;
    step();
    load_ctrl = 1'b1; load_addr = 16'd14;
    step();
    for (int a = 10; a < 14; a++) begin
      load_ctrl = 1'b1; load_addr = 16'(a);
      step();
    end
    idle(4);

    // Youngest-match forwarding, before and after the drain.
    host_we = 1'b1; host_addr = 16'd200; host_wdata = splat(32'h77);
    write_ctrl = 1'b1; write_addr = 16'd9; write_data = splat(32'd1);
    step();
    write_ctrl = 1'b1; write_addr = 16'd9; write_data = splat(32'd2);
    step();
    load_ctrl = 1'b1; load_addr = 16'd9;
    step();
    host_we = 1'b0;
    idle(4);
    load_ctrl = 1'b1; load_addr = 16'd9;
    step();

    // Address wrap on store and load ports.
    write_ctrl = 1'b1; write_addr = 16'd260; write_data = splat(32'hAB);
    step();
    load_ctrl = 1'b1; load_addr = 16'd4;
    step();
    idle(2);
    load_ctrl = 1'b1; load_addr = 16'd516;
    step();

    // Reset with three buffered stores: they must be discarded.
    host_we = 1'b1; host_addr = 16'd200; host_wdata = splat(32'h55);
    for (int a = 20; a < 23; a++) begin
      write_ctrl = 1'b1; write_addr = 16'(a); write_data = splat(32'hF00 + 32'(a));
      step();
    end
    load_ctrl = 1'b1; load_addr = 16'd20;
    step();
    reset = 1'b1; load_ctrl = 1'b1; load_addr = 16'd21; host_addr = 16'd21;
    step();
    reset = 1'b0; host_we = 1'b0;
    for (int a = 20; a < 23; a++) begin
      load_ctrl = 1'b1; load_addr = 16'(a);
      step();
    end

    // Mixed random traffic on a small aliased address set.
    for (int i = 0; i < 80; i++) begin
      load_ctrl  = 1'($urandom_range(0, 1));
      load_addr  = 16'($urandom_range(0, 7)) + 16'(256 * $urandom_range(0, 3));
      write_ctrl = 1'($urandom_range(0, 1));
      write_addr = 16'($urandom_range(0, 7)) + 16'(256 * $urandom_range(0, 3));
      write_data = rand_vec();
      host_we    = ($urandom_range(0, 3) == 0);
      host_addr  = 16'($urandom_range(0, 7));
      host_wdata = rand_vec();
      step();
    end
    host_we = 1'b0;
    idle(6);
    for (int a = 0; a < 8; a++) begin
      load_ctrl = 1'b1; load_addr = 16'(a);
      step();
    end
    idle(1);
    check("scoreboard_left", 512'(sb.size()), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pb_mem_port.md
# pb_mem_port

Main-memory port sitting directly downstream of `processing_block`: it consumes the block's `load_ctrl`/`load_addr` and `write_ctrl`/`write_addr`/`write_data` requests and returns 512-bit vectors on `load_data`. It holds the backing word memory, a small posted-write buffer that decouples vector stores from the memory write port, and a host port used by benches and the loader to preload memory. Loads see every accepted store, including stores still held in the buffer, through youngest-match forwarding.

## Interface
Parameters:
- `LANES`, 16, 32-bit lanes per vector word
- `LANE_W`, 32, lane width in bits
- `ADDR_W`, 16, address width in words
- `DEPTH`, 256, backing memory depth in 512-bit words (power of two)
- `WBUF_DEPTH`, 4, posted-write buffer entries (power of two, ≥2)

Ports:
- `clock` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `load_ctrl` in 1: load request this cycle
- `load_addr` in ADDR_W: load word address
- `load_data` out LANES*LANE_W: returned vector, registered
- `load_valid` out 1: `load_data` valid, one-cycle pulse
- `write_ctrl` in 1: store request this cycle
- `write_addr` in ADDR_W: store word address
- `write_data` in LANES*LANE_W: store vector
- `stall` out 1: write buffer full; a store offered while high is not accepted
- `host_we` in 1: host preload write
- `host_addr` in ADDR_W: host write address
- `host_wdata` in LANES*LANE_W: host write data

## Operation
- Address mapping: only `addr[log2(DEPTH)-1:0]` is used; higher bits are ignored, so addresses wrap modulo DEPTH. This applies to the load, store and host ports alike, including forwarding compares.
- Store accept: `write_ctrl && !stall` pushes `{addr, data}` into the FIFO tail. A store offered while `stall` is high is dropped; the producer must hold it and retry.
- `stall` = (count == WBUF_DEPTH), derived combinationally from registered count. A drain in the same cycle does not lift the stall.
- Drain: when the buffer is non-empty and `host_we` is low, the head entry is written to memory and popped. This is one entry per cycle. `host_we` has priority and blocks the drain for that cycle.
- Enqueue and drain in the same cycle are both performed; count is unchanged.
- Load: `load_ctrl` is sampled at edge N; `load_data`/`load_valid` are registered at edge N+1. The data source is, in priority order:
  1. a store accepted at edge N to the same address (write-before-read);
  2. the youngest valid buffer entry with a matching address;
  3. a host write at edge N to the same address;
  4. memory contents.
- When `load_ctrl` is low at edge N, `load_valid` = 0 after edge N+1 and `load_data` holds its previous value.
- Loads never stall.
- Reset: count, head and tail pointers, entry valid bits, `load_valid` and `load_data` are cleared to 0. Buffered stores are discarded. Memory array contents are untouched. A request coincident with `reset` is ignored.

## Timing
- Load latency: 1 cycle, fixed, with back-to-back issue every cycle.
- Store-to-memory: an entry enqueued at edge N into an empty buffer is written to the array at edge N+1, absent `host_we`.
- Store-to-load visibility: 0 cycles. A same-cycle load returns the new data.
- `stall` changes only after a clock edge, never combinationally from the request inputs.
- Reset values: `load_data`=0, `load_valid`=0, `stall`=0.

## Structure
- Shared package `pb_pkg`:
  - `LANES`, `LANE_W`, `WORD_W` = LANES*LANE_W, `ADDR_W`
  - typedef `vec_t` (WORD_W bits)
  - typedef `wbuf_entry_t` {valid, addr, data}
  - `processing_block` imports the same package.
- Sub-module `pb_wbuf`: circular FIFO (head/tail/count) with a combinational youngest-match lookup port (`lk_addr` → `lk_hit`, `lk_data`).
- Top level contains the memory array, the host/drain write mux, the load mux and the output registers.

## Test plan
- Host preload: preload addr 0 = all lanes 3, addr 1 = lanes 5, addr 2 = lanes 7. Load 0, 1, 2 back-to-back → `load_valid` high for 3 cycles carrying 3, 5, 7 respectively, each one cycle after its request.
- Same-cycle store and load to the same address: store lanes 22 to addr 3 while loading addr 3 in the same cycle → next cycle `load_data` = 22 in every lane.
- Full buffer:
  - Hold `host_we` high (addr 200) to block the drain and issue 4 stores (addr 10..13) → `stall`=1 after the 4th.
  - A 5th store to addr 14 is dropped: a later load of 14 returns the preloaded value.
  - Release `host_we` → `stall` clears after one drain.
  - Loads of 10..13 return the stored data.
- Youngest-match forwarding: with the drain blocked, store 1 then 2 to addr 9 → load of 9 returns 2. After the drain completes, load of 9 still returns 2.
- Wrap-around: store lanes 0xAB to addr 256+4 → load of addr 4 returns 0xAB.
- Reset mid-operation:
  - With 3 stores buffered (drain blocked), assert `reset` for 1 cycle → `stall`=0, `load_valid`=0, `load_data`=0.
  - Loads of the 3 addresses return the pre-store memory values.
